// File: rtl/tspi_pkg.sv
// Shared types and default widths for the TSPI counter blocks.
package tspi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      ACTIVE = 2'd2
   } tspi_cnt_state_e;

   localparam int unsigned TSPI_CNT_W = 8;
   localparam int unsigned TSPI_LEN_W = 6;

endpackage

// File: rtl/tspi_edge_detect.sv
// Samples an oversampled TSPI clock and emits a zero-latency strobe
// on the selected edge.
module tspi_edge_detect #(
   parameter int unsigned EDGE_POL = 0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic strobe_o
);

   logic sig_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sig_q <= 1'b0;
      else         sig_q <= sig_i;
   end

   assign strobe_o = (EDGE_POL != 0) ? (~sig_i & sig_q)
                                     : (sig_i & ~sig_q);

endmodule

// File: rtl/tspi_frame_counter.sv
// Bit/command counter between the TSPI register front-end and the
// shift engine, with load handshake, abort and done pulse.
module tspi_frame_counter
   import tspi_pkg::*;
#(
   parameter int unsigned CNT_W      = TSPI_CNT_W,
   parameter int unsigned LEN_W      = TSPI_LEN_W,
   parameter int unsigned EDGE_POL   = 0,
   parameter int unsigned WAIT_START = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tspi_clk_i,
   input  logic             clear_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] cnt_cmd_i,
   input  logic [LEN_W-1:0] len_cmd_i,
   input  logic             start_bit_i,
   output logic             load_ready_o,
   output logic             busy_o,
   output logic             bit_strobe_o,
   output logic [LEN_W-1:0] bit_idx_o,
   output logic [CNT_W-1:0] cnt_cmd_o,
   output logic             new_cmd_o,
   output logic             last_bit_o,
   output logic             done_o
);

   tspi_cnt_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
   logic             done_q, done_d;
   logic             strobe;
   tspi_cnt_state_e  cmd_next;

   tspi_edge_detect #(
      .EDGE_POL (EDGE_POL)
   ) u_edge (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sig_i    (tspi_clk_i),
      .strobe_o (strobe)
   );

   assign cmd_next = (WAIT_START != 0) ? ARMED : ACTIVE;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      bit_idx_d = bit_idx_q;
      done_d    = 1'b0;
      if (clear_i) begin
         state_d   = IDLE;
         cnt_d     = '0;
         bit_idx_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (load_i) begin
                  cnt_d     = cnt_cmd_i;
                  len_d     = len_cmd_i;
                  bit_idx_d = '0;
                  if (cnt_cmd_i == '0) done_d  = 1'b1;
                  else                 state_d = cmd_next;
               end
            end
            ARMED: begin
               // the start-bit strobe itself is not a data bit
               if (strobe && start_bit_i) state_d = ACTIVE;
            end
            ACTIVE: begin
               if (strobe) begin
                  if (bit_idx_q != len_q) begin
                     bit_idx_d = bit_idx_q + LEN_W'(1);
                  end else begin
                     bit_idx_d = '0;
                     cnt_d     = cnt_q - CNT_W'(1);
                     if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end else begin
                        state_d = cmd_next;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         bit_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         bit_idx_q <= bit_idx_d;
         done_q    <= done_d;
      end
   end

   assign load_ready_o = (state_q == IDLE);
   assign busy_o       = (state_q == ARMED) || (state_q == ACTIVE);
   assign bit_strobe_o = strobe;
   assign bit_idx_o    = bit_idx_q;
   assign cnt_cmd_o    = cnt_q;
   assign new_cmd_o    = (state_q == ACTIVE) && (bit_idx_q == '0);
   assign last_bit_o   = (state_q == ACTIVE) && (bit_idx_q == len_q);
   assign done_o       = done_q;

endmodule

// File: tb/tb_tspi_frame_counter.sv
// Scoreboard bench for tspi_frame_counter: three parameter variants
// share stimulus; one selected instance is monitored at a time.
module tb_tspi_frame_counter;

   typedef struct packed {
      logic       stb;
      logic       dne;
      logic       bsy;
      logic [5:0] idx;
      logic [7:0] cnt;
      logic       nc;
      logic       lb;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tclk = 1'b0;
   logic clear = 1'b0;
   logic load = 1'b0;
   logic [7:0] cnt_in = '0;
   logic [5:0] len_in = '0;
   logic start = 1'b0;

   logic [2:0] lr, bz, st, nc, lb, dn;
   logic [2:0][5:0] bi;
   logic [2:0][7:0] cc;

   int sel = 0;
   int vectors = 0;
   int fails = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   // dut0: back-to-back, rising edge
   tspi_frame_counter #(.CNT_W(8), .LEN_W(6), .EDGE_POL(0),
      .WAIT_START(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .tspi_clk_i(tclk),
      .clear_i(clear), .load_i(load), .cnt_cmd_i(cnt_in),
      .len_cmd_i(len_in), .start_bit_i(start),
      .load_ready_o(lr[0]), .busy_o(bz[0]),
      .bit_strobe_o(st[0]), .bit_idx_o(bi[0]),
      .cnt_cmd_o(cc[0]), .new_cmd_o(nc[0]),
      .last_bit_o(lb[0]), .done_o(dn[0]));

   // dut1: start bit required, rising edge
   tspi_frame_counter #(.CNT_W(8), .LEN_W(6), .EDGE_POL(0),
      .WAIT_START(1)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .tspi_clk_i(tclk),
      .clear_i(clear), .load_i(load), .cnt_cmd_i(cnt_in),
      .len_cmd_i(len_in), .start_bit_i(start),
      .load_ready_o(lr[1]), .busy_o(bz[1]),
      .bit_strobe_o(st[1]), .bit_idx_o(bi[1]),
      .cnt_cmd_o(cc[1]), .new_cmd_o(nc[1]),
      .last_bit_o(lb[1]), .done_o(dn[1]));

   // dut2: back-to-back, falling edge
   tspi_frame_counter #(.CNT_W(8), .LEN_W(6), .EDGE_POL(1),
      .WAIT_START(0)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .tspi_clk_i(tclk),
      .clear_i(clear), .load_i(load), .cnt_cmd_i(cnt_in),
      .len_cmd_i(len_in), .start_bit_i(start),
      .load_ready_o(lr[2]), .busy_o(bz[2]),
      .bit_strobe_o(st[2]), .bit_idx_o(bi[2]),
      .cnt_cmd_o(cc[2]), .new_cmd_o(nc[2]),
      .last_bit_o(lb[2]), .done_o(dn[2]));

   always @(negedge clk) begin
      exp_t e, a;
      if (rst_n && (st[sel] || dn[sel])) begin
         a = {st[sel], dn[sel], bz[sel], bi[sel], cc[sel],
              nc[sel], lb[sel]};
         vectors++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event dut%0d act=%h", sel, a);
         end else begin
            e = sb.pop_front();
            if (a !== e) begin
               fails++;
               $display("FAIL event dut%0d act=%h exp=%h t=%0t",
                        sel, a, e, $time);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input bit s, input bit d, input bit b,
                       input int i, input int c,
                       input bit n, input bit l);
      exp_t e;
      e = {s, d, b, 6'(i), 8'(c), n, l};
      sb.push_back(e);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   task automatic tick(input bit s);
      start = s;
      tclk  = 1'b1;
      cyc(1);
      tclk  = 1'b0;
      start = 1'b0;
      cyc(1);
   endtask

   task automatic do_load(input int c, input int l);
      cnt_in = 8'(c);
      len_in = 6'(l);
      load   = 1'b1;
      cyc(1);
      load   = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(2);
   endtask

   initial begin
      // reset state
      #2;
      for (int d = 0; d < 3; d++) begin
         chk("rst_ready", int'(lr[d]), 1);
         chk("rst_busy", int'(bz[d]), 0);
         chk("rst_cnt", int'(cc[d]), 0);
         chk("rst_done", int'(dn[d]), 0);
      end
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // 1: three 8-bit commands back to back
      sel = 0;
      do_load(3, 7);
      chk("t1_busy", int'(bz[0]), 1);
      for (int k = 0; k < 24; k++) begin
         push(1, 0, 1, k % 8, 3 - k / 8, (k % 8) == 0, (k % 8) == 7);
         if (k == 23) push(0, 1, 0, 0, 0, 0, 0);
         tick(0);
      end
      chk("t1_ready", int'(lr[0]), 1);
      do_clear();

      // 2: start-bit gated commands
      sel = 1;
      do_load(2, 3);
      for (int k = 0; k < 2; k++) begin
         push(1, 0, 1, 0, 2, 0, 0);
         tick(0);
      end
      chk("t2_armed_idx", int'(bi[1]), 0);
      for (int c = 2; c >= 1; c--) begin
         push(1, 0, 1, 0, c, 0, 0);
         tick(1);
         for (int k = 0; k < 4; k++) begin
            push(1, 0, 1, k, c, k == 0, k == 3);
            if (c == 1 && k == 3) push(0, 1, 0, 0, 0, 0, 0);
            tick(0);
         end
         if (c == 2) begin
            chk("t2_rearm_busy", int'(bz[1]), 1);
            chk("t2_rearm_new", int'(nc[1]), 0);
            chk("t2_rearm_cnt", int'(cc[1]), 1);
         end
      end
      chk("t2_ready", int'(lr[1]), 1);
      do_clear();

      // 3: one-bit commands
      sel = 0;
      do_load(5, 0);
      for (int k = 0; k < 5; k++) begin
         push(1, 0, 1, 0, 5 - k, 1, 1);
         if (k == 4) push(0, 1, 0, 0, 0, 0, 0);
         tick(0);
      end
      do_clear();

      // 4: clear beats simultaneous strobe and load
      do_load(3, 7);
      for (int k = 0; k < 12; k++) begin
         push(1, 0, 1, k % 8, 3 - k / 8, (k % 8) == 0, (k % 8) == 7);
         tick(0);
      end
      push(1, 0, 1, 4, 2, 0, 0);
      tclk   = 1'b1;
      clear  = 1'b1;
      load   = 1'b1;
      cnt_in = 8'd9;
      len_in = 6'd2;
      cyc(1);
      tclk  = 1'b0;
      clear = 1'b0;
      load  = 1'b0;
      chk("t4_busy", int'(bz[0]), 0);
      chk("t4_cnt", int'(cc[0]), 0);
      chk("t4_idx", int'(bi[0]), 0);
      chk("t4_ready", int'(lr[0]), 1);
      chk("t4_done", int'(dn[0]), 0);
      cyc(3);

      // 5: zero-command load, then load while busy
      push(0, 1, 0, 0, 0, 0, 0);
      do_load(0, 3);
      cyc(1);
      chk("t5_ready", int'(lr[0]), 1);
      do_load(2, 1);
      do_load(7, 5);
      chk("t5_busy_cnt", int'(cc[0]), 2);
      chk("t5_busy_idx", int'(bi[0]), 0);
      for (int k = 0; k < 4; k++) begin
         push(1, 0, 1, k % 2, 2 - k / 2, (k % 2) == 0, (k % 2) == 1);
         if (k == 3) push(0, 1, 0, 0, 0, 0, 0);
         tick(0);
      end
      do_clear();

      // 6: falling-edge variant, glitches, async reset
      sel  = 2;
      tclk = 1'b1;
      cyc(3);
      do_load(2, 3);
      for (int g = 0; g < 2; g++) begin
         push(1, 0, 1, g, 2, g == 0, 0);
         tclk = 1'b0;
         cyc(1);
         tclk = 1'b1;
         cyc(3);
      end
      chk("t6_idx", int'(bi[2]), 2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", int'(lr[2]), 1);
      chk("t6_rst_busy", int'(bz[2]), 0);
      chk("t6_rst_idx", int'(bi[2]), 0);
      chk("t6_rst_cnt", int'(cc[2]), 0);
      chk("t6_rst_new", int'(nc[2]), 0);
      chk("t6_rst_last", int'(lb[2]), 0);
      chk("t6_rst_done", int'(dn[2]), 0);
      chk("t6_rst_stb", int'(st[2]), 0);
      cyc(2);
      rst_n = 1'b1;
      cyc(3);

      for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1);
      chk("sb_drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, fails);
      $finish;
   end

endmodule

// File: doc/tspi_frame_counter.md
Name: tspi_frame_counter

Overview:
- Parametrised successor to the TSPI bit/command counter; sits between the TSPI register front-end and the shift engine.
- Turns rising or falling edges of the oversampled `tspi_clk_i` into bit strobes, all in the `clk_i` domain.
- Counts bits per command and commands per transfer. Optionally waits for a start bit before each command.
- Provides a load/ready handshake, an abort input and a done pulse, which the previous counter lacked.

Parameters:
- CNT_W, 8: width of the command counter; a transfer holds 0..2^CNT_W-1 commands.
- LEN_W, 6: width of the length field; a command is `len_cmd_i`+1 bits.
- EDGE_POL, 0: 0 counts rising edges of `tspi_clk_i`, 1 counts falling edges.
- WAIT_START, 1: 1 requires `start_bit_i` on a strobe before each command; 0 runs commands back-to-back.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- tspi_clk_i  in  1  TSPI clock, already synchronous to `clk_i`; sampled, never used as a clock.
- clear_i  in  1  synchronous abort; returns to IDLE.
- load_i  in  1  load request; accepted only when `load_ready_o`=1.
- cnt_cmd_i  in  CNT_W  number of commands in the transfer.
- len_cmd_i  in  LEN_W  bits per command minus 1.
- start_bit_i  in  1  start-bit qualifier, sampled on strobe in ARMED.
- load_ready_o  out  1  block is idle and accepts `load_i`.
- busy_o  out  1  state is ARMED or ACTIVE.
- bit_strobe_o  out  1  one-cycle pulse per selected TSPI edge.
- bit_idx_o  out  LEN_W  index of the current bit within the command.
- cnt_cmd_o  out  CNT_W  commands remaining.
- new_cmd_o  out  1  ACTIVE and `bit_idx`=0.
- last_bit_o  out  1  ACTIVE and `bit_idx`=`len_q`.
- done_o  out  1  one-cycle pulse when the final command completes.

Behaviour:
- One clock `clk_i`; reset `rst_ni` is asynchronous and active-low. All flops reset to 0; state resets to IDLE. All outputs are 0 at reset except `load_ready_o`=1.
- Edge detect:
  - `tclk_q` registers `tspi_clk_i` every cycle.
  - `bit_strobe_o` is combinational: `tspi_clk_i & ~tclk_q` (EDGE_POL=0) or `~tspi_clk_i & tclk_q` (EDGE_POL=1).
  - The strobe is emitted in every state and has zero latency from the input edge.
- Load:
  - `load_i` && `load_ready_o` captures `cnt_q`=`cnt_cmd_i` and `len_q`=`len_cmd_i`, and sets `bit_idx_q`=0.
  - Next state is ARMED (WAIT_START=1) or ACTIVE (WAIT_START=0).
  - If `cnt_cmd_i`=0, no state change occurs; instead `done_o` pulses in the next cycle.
  - `load_i` while busy is ignored; no captured state changes.
- IDLE: `load_ready_o`=1; strobes are ignored.
- ARMED: a strobe with `start_bit_i`=1 moves to ACTIVE. That strobe is the start bit and is not counted. A strobe with `start_bit_i`=0 is ignored.
- ACTIVE: on each strobe:
  - If `bit_idx_q` != `len_q`: `bit_idx_q`++.
  - Otherwise (last bit): `bit_idx_q`=0 and `cnt_q`--.
    - If `cnt_q` was 1: go to IDLE and register `done_o`=1 for the following cycle.
    - Otherwise: go to ARMED (WAIT_START=1) or stay in ACTIVE (WAIT_START=0).
  - No strobe: hold.
- Arithmetic: `bit_idx` never exceeds `len_q`; `cnt_q` never underflows because the 1→0 transition leaves ACTIVE. `len_q`=0 gives 1-bit commands, with `new_cmd_o` and `last_bit_o` high together. `len_q`=2^LEN_W-1 is legal.
- `clear_i`:
  - Next cycle: IDLE, `cnt_q`=0, `bit_idx_q`=0, no `done_o`.
  - Has priority over `load_i` and over strobe in the same cycle.
  - `tclk_q` keeps sampling, so a strobe is never duplicated after clear.
- Reset mid-transfer: immediate return to IDLE and zero values; no `done_o`.

Decomposition:
- `tspi_pkg` gains:
  - `tspi_cnt_state_e` (IDLE, ARMED, ACTIVE), 2-bit enum.
  - Constants `TSPI_CNT_W`=8 and `TSPI_LEN_W`=6, used as defaults.
- One sub-module, `tspi_edge_detect` (param EDGE_POL; ports `clk_i`, `rst_ni`, `sig_i`, `strobe_o`), holding the sampling flop.
- Counters and FSM stay in the top module.

Test Plan:
1. WAIT_START=0, load cnt=3 len=7, 24 rising edges → `last_bit_o` on strobes 8, 16 and 24; `cnt_cmd_o` 3→2→1→0; `done_o` pulses exactly once, one cycle after strobe 24; `load_ready_o` returns to 1.
2. WAIT_START=1, load cnt=2 len=3:
   - Strobes with `start_bit_i`=0 → state stays ARMED, `bit_idx_o`=0.
   - Start strobe then 4 strobes → command 1 completes and state returns to ARMED.
   - Repeat → `done_o` pulses.
3. len=0, cnt=5, WAIT_START=0 → `new_cmd_o` and `last_bit_o` high together in every ACTIVE cycle; `done_o` after 5 strobes.
4. `clear_i` at `bit_idx`=4 of command 2, with a simultaneous strobe and `load_i` → next cycle IDLE, counters 0, no `done_o`, load not captured.
5. `load_i` with cnt=0 → `done_o` next cycle, state stays IDLE. `load_i` while busy → `cnt_cmd_o` unchanged.
6. EDGE_POL=1, held-high `tspi_clk_i` with a 1-cycle low glitch → exactly one strobe, on the falling edge; `rst_ni` asserted mid-ACTIVE → all outputs 0 and `load_ready_o`=1 asynchronously.
